// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 sizes, FSM states,
// and the store byte-lane / data-replication helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // funct3[1:0] carries the access size; bit 2 only selects zero-extension.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_be = BE_BYTE << a;
            2'b01:   lane_be = BE_HALF << {a[1], 1'b0};
            default: lane_be = BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lo,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one req/ack data-memory transaction per instruction.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_access
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Read_data_2,
    input  logic        ALU_kick_up,
    input  logic        Controller_memread,
    input  logic        Controller_memwrite,
    input  logic [2:0]  Controller_funct3,
    output logic        Dmem_req,
    output logic        Dmem_we,
    output logic [31:0] Dmem_addr,
    output logic [31:0] Dmem_wdata,
    output logic [3:0]  Dmem_be,
    input  logic [31:0] Dmem_rdata,
    input  logic        Dmem_ack,
    output logic [31:0] MEM_result,
    output logic [31:0] MEM_read_data,
    output logic        MEM_error,
    output logic        MEM_busy,
    output logic        MEM_kick_up
);

    localparam int TMO_LAST_I = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_I[TMO_W-1:0];

    state_t            state, state_next;
    logic [1:0]        lo_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [TMO_W-1:0]  cnt;
    logic [31:0]       load_data;
    logic              mem_op;
    logic              misalign;
    logic              timeout_hit;

    mem_load_align u_align (
        .rdata  (Dmem_rdata),
        .funct3 (f3_q),
        .lo     (lo_q),
        .data   (load_data)
    );

    always_comb begin
        mem_op = Controller_memread | Controller_memwrite;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign = mem_op & is_misaligned(Controller_funct3, ALU_result[1:0]);
`else
        misalign = 1'b0;
`endif
        // The last counted cycle is ACK_TIMEOUT-1, so req is high exactly ACK_TIMEOUT cycles.
        timeout_hit = (ACK_TIMEOUT != 0) && (cnt == TMO_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ALU_kick_up) begin
                    state_next = (mem_op && !misalign) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (Dmem_ack || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Dmem_req    = (state == ST_REQ);
        MEM_busy    = (state == ST_REQ);
        MEM_kick_up = (state == ST_DONE);
        Dmem_we     = we_q & (state == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            lo_q          <= 2'b00;
            f3_q          <= 3'b000;
            we_q          <= 1'b0;
            Dmem_addr     <= 32'h0;
            Dmem_wdata    <= 32'h0;
            Dmem_be       <= 4'h0;
            MEM_result    <= 32'h0;
            MEM_read_data <= 32'h0;
            MEM_error     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_REQ && state_next == ST_REQ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            if (state == ST_IDLE && ALU_kick_up) begin
                lo_q          <= ALU_result[1:0];
                f3_q          <= Controller_funct3;
                we_q          <= Controller_memwrite;
                Dmem_addr     <= {ALU_result[31:2], 2'b00};
                Dmem_wdata    <= lane_wdata(Controller_funct3, Read_data_2);
                Dmem_be       <= lane_be(Controller_funct3, ALU_result[1:0]);
                MEM_result    <= ALU_result;
                MEM_read_data <= 32'h0;
                MEM_error     <= misalign;
            end

            if (state == ST_REQ) begin
                if (Dmem_ack) begin
                    MEM_read_data <= load_data;
                end else if (timeout_hit) begin
                    MEM_read_data <= 32'h0;
                    MEM_error     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access, built with a short ack timeout of 4 cycles.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] ALU_result;
    logic [31:0] Read_data_2;
    logic        ALU_kick_up;
    logic        Controller_memread;
    logic        Controller_memwrite;
    logic [2:0]  Controller_funct3;
    logic        Dmem_req;
    logic        Dmem_we;
    logic [31:0] Dmem_addr;
    logic [31:0] Dmem_wdata;
    logic [3:0]  Dmem_be;
    logic [31:0] Dmem_rdata;
    logic        Dmem_ack;
    logic [31:0] MEM_result;
    logic [31:0] MEM_read_data;
    logic        MEM_error;
    logic        MEM_busy;
    logic        MEM_kick_up;

    int checks   = 0;
    int failures = 0;

    mem_access #(.ACK_TIMEOUT(4), .TMO_W(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ALU_result          (ALU_result),
        .Read_data_2         (Read_data_2),
        .ALU_kick_up         (ALU_kick_up),
        .Controller_memread  (Controller_memread),
        .Controller_memwrite (Controller_memwrite),
        .Controller_funct3   (Controller_funct3),
        .Dmem_req            (Dmem_req),
        .Dmem_we             (Dmem_we),
        .Dmem_addr           (Dmem_addr),
        .Dmem_wdata          (Dmem_wdata),
        .Dmem_be             (Dmem_be),
        .Dmem_rdata          (Dmem_rdata),
        .Dmem_ack            (Dmem_ack),
        .MEM_result          (MEM_result),
        .MEM_read_data       (MEM_read_data),
        .MEM_error           (MEM_error),
        .MEM_busy            (MEM_busy),
        .MEM_kick_up         (MEM_kick_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EX must never kick while the stage is occupied.
    always @(posedge clk) begin
        if (reset && ALU_kick_up && (MEM_busy || MEM_kick_up)) begin
            failures = failures + 1;
            $display("FAIL kick_overlap busy=%0b kick=%0b", MEM_busy, MEM_kick_up);
        end
    end

    // Drive one EX pulse at a negedge; returns at the following negedge.
    task automatic issue(input logic [31:0] addr, input logic [31:0] d,
                         input logic rd, input logic wr, input logic [2:0] f3);
        ALU_result          = addr;
        Read_data_2         = d;
        Controller_memread  = rd;
        Controller_memwrite = wr;
        Controller_funct3   = f3;
        ALU_kick_up         = 1'b1;
        @(negedge clk);
        ALU_kick_up         = 1'b0;
        Controller_memread  = 1'b0;
        Controller_memwrite = 1'b0;
    endtask

    // Holds off the ack for n_wait cycles (checking req stays up), then acks once.
    task automatic ack_after(input int n_wait, input logic [31:0] rdata);
        for (int i = 0; i < n_wait; i++) begin
            checks = checks + 1;
            if (Dmem_req !== 1'b1) begin
                failures = failures + 1;
                $display("FAIL req_held cycle=%0d got=%0b exp=1", i, Dmem_req);
            end
            @(negedge clk);
        end
        Dmem_rdata = rdata;
        Dmem_ack   = 1'b1;
        @(negedge clk);
        Dmem_ack   = 1'b0;
        Dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if ({Dmem_req, Dmem_we, Dmem_be, MEM_error, MEM_busy, MEM_kick_up} !== 9'h0 ||
            Dmem_addr !== 32'h0 || Dmem_wdata !== 32'h0 ||
            MEM_result !== 32'h0 || MEM_read_data !== 32'h0) begin
            failures = failures + 1;
            $display("FAIL reset_outputs req=%0b be=%h addr=%h res=%h rd=%h exp all 0",
                     Dmem_req, Dmem_be, Dmem_addr, MEM_result, MEM_read_data);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthru();
        issue(32'h0000_1234, 32'h0, 1'b0, 1'b0, F3_W);
        checks = checks + 1;
        if (MEM_kick_up !== 1'b1 || Dmem_req !== 1'b0 || MEM_result !== 32'h1234) begin
            failures = failures + 1;
            $display("FAIL passthru kick=%0b req=%0b res=%h exp kick=1 req=0 res=00001234",
                     MEM_kick_up, Dmem_req, MEM_result);
        end
        @(negedge clk);
        checks = checks + 1;
        if (MEM_kick_up !== 1'b0 || Dmem_req !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL passthru_one_pulse kick=%0b req=%0b exp 0 0", MEM_kick_up, Dmem_req);
        end
    endtask

    task automatic test_store_word();
        issue(32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, F3_W);
        checks = checks + 1;
        if (Dmem_req !== 1'b1 || Dmem_we !== 1'b1 || Dmem_be !== 4'hF ||
            Dmem_addr !== 32'h100 || Dmem_wdata !== 32'hDEAD_BEEF || MEM_busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL sw_bus req=%0b we=%0b be=%h addr=%h wd=%h busy=%0b exp 1 1 f 00000100 deadbeef 1",
                     Dmem_req, Dmem_we, Dmem_be, Dmem_addr, Dmem_wdata, MEM_busy);
        end
        ack_after(3, 32'h0);
        checks = checks + 1;
        if (MEM_kick_up !== 1'b1 || Dmem_req !== 1'b0 || MEM_error !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL sw_done kick=%0b req=%0b err=%0b exp 1 0 0", MEM_kick_up, Dmem_req, MEM_error);
        end
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        issue(32'h0000_0103, 32'h0, 1'b1, 1'b0, F3_B);
        checks = checks + 1;
        if (Dmem_be !== 4'h8 || Dmem_we !== 1'b0 || Dmem_addr !== 32'h100) begin
            failures = failures + 1;
            $display("FAIL lb_bus be=%h we=%0b addr=%h exp 8 0 00000100", Dmem_be, Dmem_we, Dmem_addr);
        end
        ack_after(1, 32'h80FF_0000);
        checks = checks + 1;
        if (MEM_kick_up !== 1'b1 || MEM_read_data !== 32'hFFFF_FF80) begin
            failures = failures + 1;
            $display("FAIL lb_data kick=%0b rd=%h exp 1 ffffff80", MEM_kick_up, MEM_read_data);
        end
        @(negedge clk);

        issue(32'h0000_0103, 32'h0, 1'b1, 1'b0, F3_BU);
        ack_after(0, 32'h80FF_0000);
        checks = checks + 1;
        if (MEM_kick_up !== 1'b1 || MEM_read_data !== 32'h0000_0080) begin
            failures = failures + 1;
            $display("FAIL lbu_data kick=%0b rd=%h exp 1 00000080", MEM_kick_up, MEM_read_data);
        end
        @(negedge clk);
        checks = checks + 1;
        if (MEM_read_data !== 32'h0000_0080) begin
            failures = failures + 1;
            $display("FAIL lbu_hold rd=%h exp 00000080", MEM_read_data);
        end
    endtask

    task automatic test_load_half();
        issue(32'h0000_0102, 32'h0, 1'b1, 1'b0, F3_H);
        checks = checks + 1;
        if (Dmem_be !== 4'hC || Dmem_addr !== 32'h100) begin
            failures = failures + 1;
            $display("FAIL lh_bus be=%h addr=%h exp c 00000100", Dmem_be, Dmem_addr);
        end
        ack_after(2, 32'h8001_0000);
        checks = checks + 1;
        if (MEM_read_data !== 32'hFFFF_8001) begin
            failures = failures + 1;
            $display("FAIL lh_data rd=%h exp ffff8001", MEM_read_data);
        end
        @(negedge clk);

        issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, F3_HU);
        ack_after(0, 32'h1234_F00D);
        checks = checks + 1;
        if (MEM_read_data !== 32'h0000_F00D) begin
            failures = failures + 1;
            $display("FAIL lhu_data rd=%h exp 0000f00d", MEM_read_data);
        end
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        issue(32'h0000_0101, 32'h0000_0055, 1'b0, 1'b1, F3_B);
        checks = checks + 1;
        if (Dmem_be !== 4'h2 || Dmem_wdata !== 32'h5555_5555 || Dmem_we !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL sb_bus be=%h wd=%h we=%0b exp 2 55555555 1", Dmem_be, Dmem_wdata, Dmem_we);
        end
        ack_after(0, 32'h0);
        @(negedge clk);

        // Both read and write set: the store takes precedence.
        issue(32'h0000_0202, 32'hAAAA_1234, 1'b1, 1'b1, F3_H);
        checks = checks + 1;
        if (Dmem_be !== 4'hC || Dmem_wdata !== 32'h1234_1234 || Dmem_we !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL sh_bus be=%h wd=%h we=%0b exp c 12341234 1", Dmem_be, Dmem_wdata, Dmem_we);
        end
        ack_after(0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        issue(32'h0000_0300, 32'h0, 1'b1, 1'b0, F3_W);
        for (int i = 0; i < 8 && Dmem_req === 1'b1; i++) begin
            req_cycles = req_cycles + 1;
            @(negedge clk);
        end
        checks = checks + 1;
        if (req_cycles != 4) begin
            failures = failures + 1;
            $display("FAIL timeout_len req_cycles=%0d exp 4", req_cycles);
        end
        checks = checks + 1;
        if (MEM_kick_up !== 1'b1 || MEM_error !== 1'b1 || MEM_read_data !== 32'h0) begin
            failures = failures + 1;
            $display("FAIL timeout_done kick=%0b err=%0b rd=%h exp 1 1 0", MEM_kick_up, MEM_error, MEM_read_data);
        end
        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (MEM_error !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL timeout_err_hold err=%0b exp 1", MEM_error);
        end
        issue(32'h0000_0055, 32'h0, 1'b0, 1'b0, F3_W);
        checks = checks + 1;
        if (MEM_error !== 1'b0 || MEM_kick_up !== 1'b1 || MEM_result !== 32'h55) begin
            failures = failures + 1;
            $display("FAIL err_clear err=%0b kick=%0b res=%h exp 0 1 00000055", MEM_error, MEM_kick_up, MEM_result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        int kicks;
        kicks = 0;
        issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, F3_W);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (Dmem_req !== 1'b0 || MEM_busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL rst_mid_req req=%0b busy=%0b exp 0 0", Dmem_req, MEM_busy);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (MEM_kick_up === 1'b1 || Dmem_req === 1'b1) kicks = kicks + 1;
            @(negedge clk);
        end
        checks = checks + 1;
        if (kicks != 0) begin
            failures = failures + 1;
            $display("FAIL rst_mid_no_kick activity_cycles=%0d exp 0", kicks);
        end
    endtask

    task automatic test_misalign();
        issue(32'h0000_0102, 32'h0, 1'b1, 1'b0, F3_W);
`ifdef MEM_MISALIGN_TRAP_EN
        checks = checks + 1;
        if (Dmem_req !== 1'b0 || MEM_kick_up !== 1'b1 || MEM_error !== 1'b1 || MEM_read_data !== 32'h0) begin
            failures = failures + 1;
            $display("FAIL lw_misalign_trap req=%0b kick=%0b err=%0b rd=%h exp 0 1 1 0",
                     Dmem_req, MEM_kick_up, MEM_error, MEM_read_data);
        end
        @(negedge clk);
`else
        checks = checks + 1;
        if (Dmem_req !== 1'b1 || Dmem_addr !== 32'h100 || Dmem_be !== 4'hF) begin
            failures = failures + 1;
            $display("FAIL lw_misalign_bus req=%0b addr=%h be=%h exp 1 00000100 f", Dmem_req, Dmem_addr, Dmem_be);
        end
        ack_after(0, 32'h1122_3344);
        checks = checks + 1;
        if (MEM_read_data !== 32'h1122_3344 || MEM_error !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL lw_misalign_data rd=%h err=%0b exp 11223344 0", MEM_read_data, MEM_error);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        reset               = 1'b0;
        ALU_result          = 32'h0;
        Read_data_2         = 32'h0;
        ALU_kick_up         = 1'b0;
        Controller_memread  = 1'b0;
        Controller_memwrite = 1'b0;
        Controller_funct3   = 3'b000;
        Dmem_rdata          = 32'h0;
        Dmem_ack            = 1'b0;
        @(negedge clk);
        test_reset();
        test_passthru();
        test_store_word();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_timeout();
        test_reset_mid_req();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
